// File: rtl/ldpc_sym_encoder.sv
// ldpc_sym_encoder: systematic LDPC encoder, serial parity accumulation then int8 BPSK symbol stream.
// Latency: message accepted at cycle t, first symbol at t+K+1, one frame every K+N+1 cycles (no overlap).
// Backpressure: symbol/last held stable with valid high until sym_ready_i; messages only accepted in IDLE.
module ldpc_sym_encoder #(
  parameter int K   = 16,
  parameter int M   = 16,
  parameter int AMP = 32,
  localparam int AW = (K > 1) ? $clog2(K) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cfg_we_i,
  input  logic [AW-1:0] cfg_addr_i,
  input  logic [M-1:0]  cfg_mask_i,
  output logic          cfg_ready_o,
  input  logic          msg_valid_i,
  output logic          msg_ready_o,
  input  logic [K-1:0]  msg_i,
  output logic          sym_valid_o,
  input  logic          sym_ready_i,
  output logic [7:0]    sym_o,
  output logic          sym_last_o,
  output logic          busy_o
);

  localparam int N  = K + M;
  localparam int SW = $clog2(N + 1);
  // Codeword vector padded to the full index range of the symbol counter
  localparam int CW = 1 << SW;
  localparam logic [AW-1:0] LAST_BIT = AW'(K - 1);
  localparam logic [SW-1:0] LAST_SYM = SW'(N - 1);
  localparam logic [7:0]    SYM_ZERO = 8'(AMP);
  localparam logic [7:0]    SYM_ONE  = 8'(-AMP);

  typedef enum logic [1:0] {S_IDLE, S_ENC, S_EMIT} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [M-1:0]    r_gen [K];
  logic [K-1:0]    r_msg;
  logic [M-1:0]    r_par;
  logic [AW-1:0]   r_bit_idx;
  logic [SW-1:0]   r_sym_idx;
  logic            w_cfg_hit;
  logic            w_cur_bit;
  logic [CW-1:0]   w_cw;
  logic            w_cw_bit;

  // Row writes only land in IDLE and only for addresses that name a real message bit
  assign w_cfg_hit = cfg_we_i && (r_state == S_IDLE) &&
                     ({1'b0, cfg_addr_i} < (AW + 1)'(K));
  assign w_cur_bit = r_msg[r_bit_idx];
  // Systematic codeword: message bits first (bit 0 first), then parity
  assign w_cw      = {{(CW - N){1'b0}}, r_par, r_msg};
  assign w_cw_bit  = w_cw[r_sym_idx];

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: accept message, K accumulate cycles, N symbol handshakes
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (msg_valid_i) w_next = S_ENC;
      S_ENC:   if (r_bit_idx == LAST_BIT) w_next = S_EMIT;
      S_EMIT:  if (sym_ready_i && (r_sym_idx == LAST_SYM)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Generator matrix storage; rows persist across frames until rewritten or reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < K; i++) begin
        r_gen[i] <= '0;
      end
    end else if (w_cfg_hit) begin
      r_gen[cfg_addr_i] <= cfg_mask_i;
    end
  end

  // Message capture, serial parity accumulation and symbol index advance
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_msg     <= '0;
      r_par     <= '0;
      r_bit_idx <= '0;
      r_sym_idx <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (msg_valid_i) begin
            r_msg     <= msg_i;
            r_par     <= '0;
            r_bit_idx <= '0;
          end
        end
        S_ENC: begin
          r_par     <= r_par ^ (w_cur_bit ? r_gen[r_bit_idx] : '0);
          r_bit_idx <= r_bit_idx + AW'(1);
          if (r_bit_idx == LAST_BIT) begin
            r_sym_idx <= '0;
          end
        end
        S_EMIT: begin
          if (sym_ready_i) begin
            r_sym_idx <= r_sym_idx + SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state only, so nothing depends on sym_ready_i
  always_comb begin
    cfg_ready_o = 1'b0;
    msg_ready_o = 1'b0;
    sym_valid_o = 1'b0;
    sym_o       = 8'h00;
    sym_last_o  = 1'b0;
    busy_o      = 1'b0;
    case (r_state)
      S_IDLE: begin
        cfg_ready_o = 1'b1;
        msg_ready_o = 1'b1;
      end
      S_ENC: begin
        busy_o = 1'b1;
      end
      S_EMIT: begin
        busy_o      = 1'b1;
        sym_valid_o = 1'b1;
        sym_o       = w_cw_bit ? SYM_ONE : SYM_ZERO;
        sym_last_o  = (r_sym_idx == LAST_SYM);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ldpc_sym_encoder.sv
// Bench for ldpc_sym_encoder: directed frames checked against a queue-based codeword model.
module tb_ldpc_sym_encoder;

  localparam int K   = 16;
  localparam int M   = 16;
  localparam int N   = K + M;
  localparam int AMP = 32;
  localparam int AW  = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cfg_we_i;
  logic [AW-1:0] cfg_addr_i;
  logic [M-1:0]  cfg_mask_i;
  logic          cfg_ready_o;
  logic          msg_valid_i;
  logic          msg_ready_o;
  logic [K-1:0]  msg_i;
  logic          sym_valid_o;
  logic          sym_ready_i;
  logic [7:0]    sym_o;
  logic          sym_last_o;
  logic          busy_o;

  ldpc_sym_encoder #(.K(K), .M(M), .AMP(AMP)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cfg_we_i    (cfg_we_i),
    .cfg_addr_i  (cfg_addr_i),
    .cfg_mask_i  (cfg_mask_i),
    .cfg_ready_o (cfg_ready_o),
    .msg_valid_i (msg_valid_i),
    .msg_ready_o (msg_ready_o),
    .msg_i       (msg_i),
    .sym_valid_o (sym_valid_o),
    .sym_ready_i (sym_ready_i),
    .sym_o       (sym_o),
    .sym_last_o  (sym_last_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] s;
    logic       l;
  } exp_t;

  int         n_chk  = 0;
  int         n_fail = 0;
  int         cyc    = 0;
  int         acc_cnt = 0;
  int         done_cnt = 0;
  int         hs_frame = 0;
  int         enc_left = 0;
  bit         emit_seen = 1'b0;
  bit         stall_prev = 1'b0;
  bit         was_idle;
  bit         bp_en = 1'b0;
  logic [7:0] prev_s;
  logic       prev_l;
  logic [M-1:0] mg [K];
  exp_t       q[$];
  logic [7:0] cap_s[$];
  logic       cap_l[$];
  logic [7:0] ref_s[$];
  int         acc_cyc[$];
  int         first_vld[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Parity from the model's generator: XOR of rows selected by message 1-bits
  function automatic logic [M-1:0] model_parity(input logic [K-1:0] m);
    logic [M-1:0] p = '0;
    for (int i = 0; i < K; i++) if (m[i]) p ^= mg[i];
    return p;
  endfunction

  always @(posedge clk_i) cyc <= cyc + 1;

  // Reference model and checker, sampled mid-cycle
  always @(negedge clk_i) begin
    if (rst_i) begin
      q.delete();
      enc_left   = 0;
      stall_prev = 1'b0;
      hs_frame   = 0;
      for (int i = 0; i < K; i++) mg[i] = '0;
    end else begin
      was_idle = (q.size() == 0);
      if (was_idle) begin
        chk("idle_msg_ready", msg_ready_o, 1);
        chk("idle_cfg_ready", cfg_ready_o, 1);
        chk("idle_sym_valid", sym_valid_o, 0);
        chk("idle_busy", busy_o, 0);
        chk("idle_sym_zero", sym_o, 0);
      end else if (enc_left > 0) begin
        chk("enc_msg_ready", msg_ready_o, 0);
        chk("enc_cfg_ready", cfg_ready_o, 0);
        chk("enc_sym_valid", sym_valid_o, 0);
        chk("enc_busy", busy_o, 1);
        chk("enc_sym_zero", sym_o, 0);
        enc_left--;
      end else begin
        if (!emit_seen) begin
          first_vld.push_back(cyc);
          emit_seen = 1'b1;
        end
        chk("emit_sym_valid", sym_valid_o, 1);
        chk("emit_busy", busy_o, 1);
        chk("emit_msg_ready", msg_ready_o, 0);
        chk("emit_cfg_ready", cfg_ready_o, 0);
        chk("sym_value", sym_o, q[0].s);
        chk("sym_last", sym_last_o, q[0].l);
        if (stall_prev) begin
          chk("stall_hold_sym", sym_o, prev_s);
          chk("stall_hold_last", sym_last_o, prev_l);
        end
        prev_s     = sym_o;
        prev_l     = sym_last_o;
        stall_prev = !sym_ready_i;
        if (sym_ready_i) begin
          cap_s.push_back(sym_o);
          cap_l.push_back(sym_last_o);
          hs_frame++;
          q.delete(0);
          if (q.size() == 0) done_cnt++;
        end
      end
      if (was_idle && cfg_we_i && int'(cfg_addr_i) < K) mg[cfg_addr_i] = cfg_mask_i;
      if (was_idle && msg_valid_i) begin
        logic [M-1:0] p;
        logic         b;
        exp_t         e;
        p = model_parity(msg_i);
        for (int i = 0; i < N; i++) begin
          b   = (i < K) ? msg_i[i] : p[i-K];
          e.s = b ? 8'(-AMP) : 8'(AMP);
          e.l = (i == N - 1);
          q.push_back(e);
        end
        enc_left  = K;
        emit_seen = 1'b0;
        hs_frame  = 0;
        acc_cnt++;
        acc_cyc.push_back(cyc);
      end
    end
  end

  // Downstream ready: always high, or a random stall pattern
  initial begin
    sym_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      sym_ready_i = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic cfg_write(input int a, input logic [M-1:0] mask);
    cfg_we_i   = 1'b1;
    cfg_addr_i = AW'(a);
    cfg_mask_i = mask;
    @(posedge clk_i); #1;
    cfg_we_i   = 1'b0;
  endtask

  task automatic run_frame(input logic [K-1:0] m, input bit bp);
    int a0 = acc_cnt;
    int d0 = done_cnt;
    int t  = 0;
    cap_s.delete();
    cap_l.delete();
    bp_en       = bp;
    msg_i       = m;
    msg_valid_i = 1'b1;
    while (acc_cnt == a0 && t < 100) begin @(posedge clk_i); #1; t++; end
    msg_valid_i = 1'b0;
    while (done_cnt == d0 && t < 1000) begin @(posedge clk_i); #1; t++; end
    bp_en = 1'b0;
    chk("frame_completes", done_cnt - d0, 1);
  endtask

  // Hand-derived codeword bits {parity, message} compared against captured symbols
  task automatic check_cap(input string nm, input logic [N-1:0] bits);
    chk({nm, "_count"}, cap_s.size(), N);
    if (cap_s.size() == N) begin
      for (int i = 0; i < N; i++) begin
        chk({nm, "_sym"}, cap_s[i], bits[i] ? 32'h0000_00E0 : 32'h0000_0020);
        chk({nm, "_last"}, cap_l[i], (i == N - 1) ? 1 : 0);
      end
    end
  endtask

  initial begin
    int a0;
    int d0;
    int t;
    rst_i       = 1'b1;
    cfg_we_i    = 1'b0;
    cfg_addr_i  = '0;
    cfg_mask_i  = '0;
    msg_valid_i = 1'b0;
    msg_i       = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_sym_valid", sym_valid_o, 0);
    chk("rst_sym_last", sym_last_o, 0);
    chk("rst_sym", sym_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_msg_ready", msg_ready_o, 1);
    chk("rst_cfg_ready", cfg_ready_o, 1);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Identity generator
    for (int i = 0; i < K; i++) cfg_write(i, M'(1) << i);
    chk("model_pin_identity", model_parity(16'h0005), 16'h0005);
    run_frame(16'h0005, 1'b0);
    check_cap("identity", {16'h0005, 16'h0005});

    // Backpressure versus an unstalled reference run
    run_frame(16'hA5A5, 1'b0);
    check_cap("a5a5", {16'hA5A5, 16'hA5A5});
    ref_s = cap_s;
    run_frame(16'hA5A5, 1'b1);
    chk("bp_handshakes", cap_s.size(), N);
    if (cap_s.size() == N && ref_s.size() == N)
      for (int i = 0; i < N; i++) chk("bp_same_sequence", cap_s[i], ref_s[i]);

    // Dense generator
    for (int i = 0; i < K; i++) cfg_write(i, 16'hFFFF);
    chk("model_pin_dense7", model_parity(16'h0007), 16'hFFFF);
    chk("model_pin_dense3", model_parity(16'h0003), 16'h0000);
    run_frame(16'h0007, 1'b0);
    check_cap("dense7", {16'hFFFF, 16'h0007});
    run_frame(16'h0003, 1'b0);
    check_cap("dense3", {16'h0000, 16'h0003});

    // Config write during ENC must be ignored
    for (int i = 0; i < K; i++) cfg_write(i, 16'h0000);
    a0 = acc_cnt;
    fork
      run_frame(16'hFFFF, 1'b0);
      begin
        t = 0;
        do begin @(posedge clk_i); #1; t++; end while (acc_cnt == a0 && t < 100);
        @(posedge clk_i); #1;
        cfg_we_i   = 1'b1;
        cfg_addr_i = '0;
        cfg_mask_i = 16'hFFFF;
        #1;
        chk("busy_cfg_ready", cfg_ready_o, 0);
        @(posedge clk_i); #1;
        cfg_we_i = 1'b0;
      end
    join
    check_cap("busy_cfg", {16'h0000, 16'hFFFF});
    run_frame(16'hFFFF, 1'b0);
    check_cap("busy_cfg_next", {16'h0000, 16'hFFFF});

    // Reset in EMIT at symbol index 5
    for (int i = 0; i < K; i++) cfg_write(i, M'(1) << i);
    msg_i       = 16'h0001;
    msg_valid_i = 1'b1;
    a0 = acc_cnt;
    t  = 0;
    while (acc_cnt == a0 && t < 100) begin @(posedge clk_i); #1; t++; end
    msg_valid_i = 1'b0;
    while (hs_frame < 5 && t < 200) begin @(posedge clk_i); #1; t++; end
    chk("rst_mid_reached_idx5", hs_frame, 5);
    rst_i = 1'b1;
    #1;
    chk("rst_mid_sym_valid", sym_valid_o, 0);
    chk("rst_mid_msg_ready", msg_ready_o, 1);
    chk("rst_mid_sym", sym_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    run_frame(16'h0001, 1'b0);
    check_cap("after_rst", {16'h0000, 16'h0001});

    // Back-to-back timing with msg_valid held high
    acc_cyc.delete();
    first_vld.delete();
    a0 = acc_cnt;
    d0 = done_cnt;
    t  = 0;
    msg_i       = 16'h1234;
    msg_valid_i = 1'b1;
    while (acc_cnt < a0 + 2 && t < 300) begin @(posedge clk_i); #1; t++; end
    msg_valid_i = 1'b0;
    while (done_cnt < d0 + 2 && t < 400) begin @(posedge clk_i); #1; t++; end
    chk("b2b_frames_done", done_cnt - d0, 2);
    chk("b2b_accepts", acc_cyc.size(), 2);
    if (acc_cyc.size() >= 2 && first_vld.size() >= 1) begin
      chk("first_valid_latency", first_vld[0] - acc_cyc[0], 17);
      chk("frame_period", acc_cyc[1] - acc_cyc[0], 49);
    end else begin
      chk("b2b_timestamps_present", 0, 1);
    end

    repeat (3) @(posedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
